// File: rtl/sram_arbiter_if.sv
// Bundle of the IF/LS request-response channels and the SRAM port shared by sram_arbiter.
// The arbiter takes the slave modport; the requesters/SRAM side takes master.
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              if_rsp_err;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [3:0]        ls_req_we;
    logic [DATA_W-1:0] ls_req_wdata;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rsp_data;
    logic              ls_rsp_err;

    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        output sram_w_en, sram_address, sram_write_data,
        input  sram_read_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        input  sram_w_en, sram_address, sram_write_data,
        output sram_read_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester (IF read-only, LS read/write) arbiter/sequencer for a single-port byte SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise LS has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              id_ls_q, id_ls_d;
    logic              err_q, err_d;

    logic              grant_if, grant_ls, accept, ls_err, if_err;

`ifdef SRAM_ARB_RR_EN
    logic              favour_ls_q, favour_ls_d;
`endif

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (bus.if_req_valid && bus.ls_req_valid) begin
`ifdef SRAM_ARB_RR_EN
            grant_ls = favour_ls_q;
            grant_if = !favour_ls_q;
`else
            grant_ls = 1'b1;
`endif
        end else begin
            grant_if = bus.if_req_valid;
            grant_ls = bus.ls_req_valid;
        end
    end

    // Accepts are allowed in IDLE and RESP, which is what gives back-to-back throughput.
    assign accept = !rst && (state_q != ACCESS) && (grant_if || grant_ls);

    always_comb begin
        case (bus.ls_req_we)
            4'b0000, 4'b1111: ls_err = (bus.ls_req_addr[1:0] != 2'b00);
            4'b0011:          ls_err = bus.ls_req_addr[0];
            4'b0001:          ls_err = 1'b0;
            default:          ls_err = 1'b1;
        endcase
    end

    assign if_err = (bus.if_req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        id_ls_d = id_ls_q;
        err_d   = err_q;
`ifdef SRAM_ARB_RR_EN
        favour_ls_d = favour_ls_q;
`endif

        case (state_q)
            ACCESS: begin
                state_d = RESP;
                rdata_d = (we_q == 4'b0000 && !err_q) ? bus.sram_read_data : '0;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = ACCESS;
            if (grant_ls) begin
                addr_d  = bus.ls_req_addr;
                we_d    = bus.ls_req_we;
                wdata_d = bus.ls_req_wdata;
                id_ls_d = 1'b1;
                err_d   = ls_err;
            end else begin
                addr_d  = bus.if_req_addr;
                we_d    = '0;
                id_ls_d = 1'b0;
                err_d   = if_err;
            end
`ifdef SRAM_ARB_RR_EN
            favour_ls_d = grant_if;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            id_ls_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            favour_ls_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            id_ls_q <= id_ls_d;
            err_q   <= err_d;
`ifdef SRAM_ARB_RR_EN
            favour_ls_q <= favour_ls_d;
`endif
        end
    end

    // rst gates the write strobe combinationally so a reset in ACCESS suppresses the commit.
    assign bus.sram_w_en       = (state_q == ACCESS && !err_q && !rst) ? we_q : '0;
    assign bus.sram_address    = addr_q;
    assign bus.sram_write_data = wdata_q;

    assign bus.if_req_ready = accept && grant_if;
    assign bus.ls_req_ready = accept && grant_ls;

    assign bus.if_rsp_valid = (state_q == RESP) && !id_ls_q;
    assign bus.ls_rsp_valid = (state_q == RESP) && id_ls_q;
    assign bus.if_rsp_data  = bus.if_rsp_valid ? rdata_q : '0;
    assign bus.ls_rsp_data  = bus.ls_rsp_valid ? rdata_q : '0;
    assign bus.if_rsp_err   = bus.if_rsp_valid && err_q;
    assign bus.ls_rsp_err   = bus.ls_rsp_valid && err_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: byte-array reference memory, queue of expected responses,
// independent monitor; honours SRAM_ARB_RR_EN for the tie-break expectation.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_clear;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
    sram_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
        bit          err;
        int unsigned cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    bit          wen_act = 1'b0;
    int unsigned wen_cyc = 0;
    logic [3:0]  wen_val = 4'h0;
    logic [15:0] wen_addr = 16'h0;
    int unsigned next_ok_cyc = 0;
    bit          favour_ls = 1'b0;
    bit          ovr_en = 1'b0;
    bit          ovr_ls = 1'b0;
    logic [31:0] ovr_data = 32'h0;

    logic [7:0]  sram_mem [65536];
    logic [7:0]  ref_mem  [65536];
    logic [15:0] ra1, ra2, ra3;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: byte lanes written at address+lane on posedge, combinational read.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 65536; i++) sram_mem[i] <= 8'h00;
        end else begin
            for (int k = 0; k < 4; k++)
                if (bus.sram_w_en[k]) sram_mem[bus.sram_address + 16'(k)] <= bus.sram_write_data[8*k +: 8];
        end
    end
    assign ra1 = bus.sram_address + 16'd1;
    assign ra2 = bus.sram_address + 16'd2;
    assign ra3 = bus.sram_address + 16'd3;
    assign bus.sram_read_data = {sram_mem[ra3], sram_mem[ra2], sram_mem[ra1], sram_mem[bus.sram_address]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    // Access size in bytes for a write mask; 0 marks an illegal mask. A read is a word access.
    function automatic int bytes_of(input logic [3:0] we);
        case (we)
            4'b0000: return 4;
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic drive_cycle(input bit ifv, input logic [15:0] ifa, input bit lsv,
                               input logic [15:0] lsa, input logic [3:0] lwe, input logic [31:0] lwd,
                               output bit acc_if, output bit acc_ls);
        bit   ok, tie_if, e_if, e_ls;
        int   nb;
        rsp_t r;
        logic [15:0] ix;
        @(posedge clk);
        #1;
        bus.if_req_valid = ifv;
        bus.if_req_addr  = ifa;
        bus.ls_req_valid = lsv;
        bus.ls_req_addr  = lsa;
        bus.ls_req_we    = lwe;
        bus.ls_req_wdata = lwd;
        #1;
        ok = (cyc >= next_ok_cyc);
`ifdef SRAM_ARB_RR_EN
        tie_if = !favour_ls;
`else
        tie_if = 1'b0;
`endif
        e_if = ok && ifv && (!lsv || tie_if);
        e_ls = ok && lsv && !e_if;
        check("if_req_ready", bus.if_req_ready, e_if);
        check("ls_req_ready", bus.ls_req_ready, e_ls);
        acc_if = ifv && bus.if_req_ready;
        acc_ls = lsv && bus.ls_req_ready;
        if (e_if || e_ls) begin
            r.is_ls = e_ls;
            r.cyc   = cyc + 2;
            r.data  = '0;
            if (e_if) begin
                r.err    = (ifa % 4) != 0;
                if (!r.err) r.data = ref_word(ifa);
                wen_val  = 4'h0;
                wen_addr = ifa;
            end else begin
                nb    = bytes_of(lwe);
                r.err = (nb == 0) || ((lsa % nb) != 0);
                if (!r.err && lwe == 4'b0000) r.data = ref_word(lsa);
                if (!r.err && lwe != 4'b0000)
                    for (int k = 0; k < nb; k++) begin
                        ix = lsa + 16'(k);
                        ref_mem[ix] = lwd[8*k +: 8];
                    end
                wen_val  = r.err ? 4'h0 : lwe;
                wen_addr = lsa;
            end
            if (ovr_en && (ovr_ls == e_ls)) r.data = ovr_data;
            wen_cyc     = cyc + 1;
            wen_act     = 1'b1;
            next_ok_cyc = cyc + 2;
            favour_ls   = e_if;
            exp_q.push_back(r);
        end
    endtask

    task automatic request(input bit is_ls, input logic [15:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input bit ovr, input logic [31:0] od,
                           output int unsigned acc_cyc);
        bit ai, al, done;
        done    = 1'b0;
        acc_cyc = 0;
        ovr_en = ovr; ovr_ls = is_ls; ovr_data = od;
        for (int n = 0; n < 8 && !done; n++) begin
            drive_cycle(!is_ls, a, is_ls, a, we, wd, ai, al);
            if (ai || al) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
        end
        ovr_en = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr %h not accepted within 8 cycles", a);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        exp_q.delete();
        wen_act = 1'b0;
        #1;
        check("ready_in_rst_if", bus.if_req_ready, 1'b0);
        check("ready_in_rst_ls", bus.ls_req_ready, 1'b0);
        check("w_en_in_rst", bus.sram_w_en, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        favour_ls   = 1'b0;
        next_ok_cyc = 0;
    endtask

    // Monitor: compares the SRAM strobe every cycle and pops the scoreboard on each response pulse.
    initial begin
        rsp_t e;
        logic [3:0] exp_w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_w = (wen_act && cyc == wen_cyc) ? wen_val : 4'h0;
                check("sram_w_en", bus.sram_w_en, exp_w);
                if (wen_act && cyc == wen_cyc) check("sram_address", bus.sram_address, wen_addr);
                if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", {bus.if_rsp_valid, bus.ls_rsp_valid}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_who", {bus.if_rsp_valid, bus.ls_rsp_valid}, e.is_ls ? 2'b01 : 2'b10);
                        check("rsp_cycle", cyc, e.cyc);
                        check("rsp_data", e.is_ls ? bus.ls_rsp_data : bus.if_rsp_data, e.data);
                        check("rsp_err", e.is_ls ? bus.ls_rsp_err : bus.if_rsp_err, e.err);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    check("rsp_missing", {bus.if_rsp_valid, bus.ls_rsp_valid}, e.is_ls ? 2'b01 : 2'b10);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c1, c2, c;
        bit          ai, al;
        int          cnt_if, cnt_acc, nmis;
        logic [31:0] old40, wd;
        logic [15:0] ia, la;
        logic [3:0]  we;
        logic [3:0]  we_tab [5];

        rst = 1'b1;
        mem_clear = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
        bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0;
        bus.ls_req_we = '0;      bus.ls_req_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        check("rst_if_ready", bus.if_req_ready, 1'b0);
        check("rst_ls_ready", bus.ls_req_ready, 1'b0);
        check("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
        check("rst_ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
        check("rst_if_rsp_err", bus.if_rsp_err, 1'b0);
        check("rst_ls_rsp_err", bus.ls_rsp_err, 1'b0);
        check("rst_if_rsp_data", bus.if_rsp_data, 32'h0);
        check("rst_ls_rsp_data", bus.ls_rsp_data, 32'h0);
        check("rst_w_en", bus.sram_w_en, 4'h0);
        check("rst_address", bus.sram_address, 16'h0);
        check("rst_wdata", bus.sram_write_data, 32'h0);
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        #1;
        check("rst_valid_if_ready", bus.if_req_ready, 1'b0);
        check("rst_valid_ls_ready", bus.ls_req_ready, 1'b0);
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        favour_ls = 1'b0;
        next_ok_cyc = 0;

        // Directed: write/read, byte merge, error cases, unchanged memory.
        request(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, c);
        request(1'b1, 16'h0010, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, c);
        request(1'b1, 16'h0011, 4'h1, 32'h000000AA, 1'b1, 32'h0, c);
        request(1'b1, 16'h0010, 4'h0, 32'h0,        1'b1, 32'hDEADAAEF, c);
        request(1'b1, 16'h0020, 4'b0010, 32'h11111111, 1'b0, 32'h0, c);
        request(1'b1, 16'h0022, 4'hF, 32'h22222222, 1'b0, 32'h0, c);
        request(1'b1, 16'h0020, 4'h0, 32'h0,        1'b1, 32'h0, c);
        request(1'b0, 16'h0000, 4'h0, 32'h0, 1'b0, 32'h0, c1);
        request(1'b0, 16'h0004, 4'h0, 32'h0, 1'b0, 32'h0, c2);
        check("b2b_accept_gap", c2 - c1, 32'd2);
        request(1'b0, 16'h0012, 4'h0, 32'h0, 1'b1, 32'h0, c);
        request(1'b1, 16'hFFFF, 4'h1, 32'h0000005A, 1'b1, 32'h0, c);
        request(1'b1, 16'hFFFC, 4'h0, 32'h0, 1'b1, 32'h5A000000, c);
        drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 4'h0, 32'h0, ai, al);

        // Reset during ACCESS of a word write: no commit, no response.
        old40 = ref_word(16'h0040);
        request(1'b1, 16'h0040, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, c);
        do_reset();
        for (int k = 0; k < 4; k++) ref_mem[16'h0040 + 16'(k)] = old40[8*k +: 8];
        check("rst_write_suppressed", {sram_mem[16'h0043], sram_mem[16'h0042], sram_mem[16'h0041], sram_mem[16'h0040]}, old40);

        // Both valid continuously straight after reset.
        cnt_if = 0;
        cnt_acc = 0;
        for (int n = 0; n < 16; n++) begin
            drive_cycle(1'b1, 16'h0000, 1'b1, 16'h0004, 4'h0, 32'h0, ai, al);
            cnt_if  += int'(ai);
            cnt_acc += int'(ai || al);
        end
        check("tie_accepts", cnt_acc, 32'd8);
`ifdef SRAM_ARB_RR_EN
        check("tie_if_grants", cnt_if, 32'd4);
`else
        check("tie_if_grants", cnt_if, 32'd0);
`endif

        // Randomized traffic around the low region and the top of the address space.
        we_tab[0] = 4'b0000; we_tab[1] = 4'b0001; we_tab[2] = 4'b0011; we_tab[3] = 4'b1111; we_tab[4] = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            ia = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 63));
            la = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                ia = ia & 16'hFFFC;
                la = la & 16'hFFFC;
            end
            we = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : we_tab[$urandom_range(0, 4)];
            wd = $urandom();
            drive_cycle(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), la, we, wd, ai, al);
        end

        repeat (4) drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 4'h0, 32'h0, ai, al);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        nmis = 0;
        for (int i = 0; i < 256; i++) if (sram_mem[i] !== ref_mem[i]) nmis++;
        for (int i = 65520; i < 65536; i++) if (sram_mem[i] !== ref_mem[i]) nmis++;
        check("memory_mismatches", nmis, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer for the single-port byte-addressed data SRAM (16-bit address, 32-bit little-endian data, `w_en` masks 0001/0011/1111, write on posedge, combinational read). It shares the SRAM between instruction fetch (IF, read-only) and load/store (LS, read/write). It checks alignment and mask legality, registers each access for one SRAM cycle, and returns a one-cycle response pulse to the winner.

## Interface
- `ADDR_W`, 16, SRAM byte-address width.
- `DATA_W`, 32, data width; fixed at 32 (mask logic assumes 4 bytes).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  IF read request.
- `if_req_ready`  out  1  IF request accepted this cycle when `valid&ready`.
- `if_req_addr`  in  ADDR_W  IF word address.
- `if_rsp_valid`  out  1  one-cycle response pulse.
- `if_rsp_data`  out  32  read data.
- `if_rsp_err`  out  1  misaligned request.
- `ls_req_valid`, `ls_req_ready`, `ls_req_addr`  in/out/in  1/1/ADDR_W  LS handshake, same rules as IF.
- `ls_req_we`  in  4  0000 read, 0001 byte, 0011 half, 1111 word write; all other values are illegal.
- `ls_req_wdata`  in  32  write data, byte 0 in [7:0].
- `ls_rsp_valid`, `ls_rsp_data`, `ls_rsp_err`  out  1/32/1  LS response.
- `sram_w_en`  out  4  to SRAM `w_en`.
- `sram_address`  out  ADDR_W  to SRAM `address`.
- `sram_write_data`  out  32  to SRAM `write_data`.
- `sram_read_data`  in  32  from SRAM `read_data`.

## Operation
- FSM states are IDLE, ACCESS and RESP; reset state is IDLE.
- Request acceptance:
  - `*_req_ready` is high only for the arbitration winner, and only when the state is not ACCESS.
  - At most one ready is high per cycle.
  - On accept: latch addr, we (IF forces 0000), wdata and requester id; go to ACCESS.
- Error check at accept, result latched:
  - Illegal `ls_req_we` is an error.
  - Word read or write with addr[1:0]≠0 is an error.
  - Half write with addr[0]≠0 is an error.
  - Byte accesses never error.
  - IF with addr[1:0]≠0 is an error.
- ACCESS (exactly one cycle):
  - `sram_address` = latched addr.
  - `sram_w_en` = latched we, or 0000 if the access has an error.
  - `sram_write_data` = latched wdata.
  - At the end of the cycle, capture `sram_read_data` into the response register; go to RESP.
- RESP (one cycle):
  - Winner's `*_rsp_valid`=1.
  - `*_rsp_data` = captured data for reads; 0 for writes and errors.
  - `*_rsp_err` = latched error.
  - If a new request is accepted in RESP, go to ACCESS; otherwise go to IDLE.
- There is no response backpressure; requesters must sink the pulse.
- Arbitration with both valid:
  - Policy is set per Configuration.
  - A single valid requester always wins.
- Outside ACCESS: `sram_w_en`=0000; `sram_address` and `sram_write_data` hold their last values.

## Timing
- Accept at edge E0, SRAM access during cycle E0→E1, write commits at E1, response during cycle E1→E2.
- Request-to-response latency: 2 cycles.
- Peak throughput: one access per 2 cycles (back-to-back accepts happen in RESP).
- Reset values:
  - State IDLE.
  - All `*_req_ready`, `*_rsp_valid`, `*_rsp_err` = 0.
  - `*_rsp_data`=0, `sram_w_en`=0000, `sram_address`=0, `sram_write_data`=0.
  - RR pointer favours IF.
- `sram_w_en` is combinationally forced to 0000 whenever `rst`=1.
  - `rst` asserted during ACCESS therefore suppresses the write.
  - The pending response is dropped (no `rsp_valid` after reset).
- `*_req_ready` is 0 while `rst`=1.
- Requester-side `valid` withdrawn before acceptance is legal; nothing is latched.
- Address wrap: a byte at 0xFFFF is accepted. Half/word at the top are only possible when aligned, so no wrap occurs through the arbiter.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - On a tie, grant the requester not granted last.
  - The pointer updates on every accept.
  - After reset, IF wins the first tie.
- `SRAM_ARB_RR_EN` undefined: fixed priority; LS always wins ties and IF waits.

## Test plan
- LS word write 0xDEADBEEF at 0x0010, then LS read 0x0010 → `ls_rsp_valid` two cycles after each accept; read data 0xDEADBEEF, err=0.
- LS byte write 0xAA at 0x0011 over that word, then read 0x0010 → 0xDEADAAEF.
- LS `we`=0010 at 0x0020, and LS word write at 0x0022 → `ls_rsp_err`=1, `sram_w_en` stays 0000, memory at 0x0020 unchanged.
- IF and LS valid continuously, IF addr 0x0000 and LS addr 0x0004 → with RR_EN grants alternate IF, LS, IF…; without it LS wins every grant.
- Back-to-back IF reads 0x0000, 0x0004 → accepts 2 cycles apart, responses 2 cycles apart, no idle cycle.
- `rst` pulsed during ACCESS of an LS word write to 0x0040 → `sram_w_en`=0000 that cycle, no `ls_rsp_valid`, 0x0040 unchanged, state IDLE.
